// File: rtl/apb_spi_bridge.sv
// APB3 slave front-end for the 16-bit SPI master core: TX FIFO, launch FSM,
// RX holding register with overrun flag and a registered receive interrupt.
module apb_spi_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        send,
  output logic [15:0] data_in,
  input  logic [15:0] data_out,
  input  logic        done,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [1:0]         ctrl_q, ctrl_d;
  logic [1:0]         state_q, state_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [15:0]        mem_d [FIFO_DEPTH];
  logic [15:0]        data_in_q, data_in_d;
  logic [15:0]        rx_reg_q, rx_reg_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_ovr_q, rx_ovr_d;
  logic               irq_q, irq_d;

  logic               access, pslverr, wr_ok, rd_ok;
  logic [1:0]         sel;
  logic [FIFO_AW:0]   level;
  logic               tx_empty, tx_full, push, pop, capture, rx_clr;
  logic [31:0]        status, prdata;
  logic               unused_pwdata;

  assign unused_pwdata = ^PWDATA[31:16];

  always_comb begin
    access   = PSEL & PENABLE;
    sel      = PADDR[3:2];
    level    = wr_ptr_q - rd_ptr_q;
    tx_empty = (level == '0);
    tx_full  = (level == DEPTH_L);
    // Misaligned accesses and pushes into a full FIFO are refused without side effects.
    pslverr  = access & ((PADDR[1:0] != 2'b00) | (PWRITE & (sel == 2'd2) & tx_full));
    wr_ok    = access & PWRITE & ~pslverr;
    rd_ok    = access & ~PWRITE & ~pslverr;

    status    = '0;
    status[0] = (state_q != ST_IDLE);
    status[1] = tx_full;
    status[2] = tx_empty;
    status[3] = rx_valid_q;
    status[4] = rx_ovr_q;
    status[8+FIFO_AW:8] = level;

    prdata = '0;
    if (rd_ok) begin
      case (sel)
        2'd0:    prdata = {30'b0, ctrl_q};
        2'd1:    prdata = status;
        2'd3:    prdata = {16'b0, rx_reg_q};
        default: prdata = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ok && sel == 2'd0) ctrl_d = PWDATA[1:0];

    push = wr_ok & (sel == 2'd2);
    pop  = (state_q == ST_IDLE) & ctrl_q[0] & ~tx_empty;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[FIFO_AW-1:0]] = PWDATA[15:0];
    wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(pop);

    // The head is latched as the FSM enters LAUNCH so data_in is valid with send.
    data_in_d = data_in_q;
    if (pop) data_in_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pop) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    capture = (state_q == ST_WAIT) & done;
    rx_clr  = rd_ok & (sel == 2'd3);

    rx_reg_d = capture ? data_out : rx_reg_q;
    if (capture)     rx_valid_d = 1'b1;
    else if (rx_clr) rx_valid_d = 1'b0;
    else             rx_valid_d = rx_valid_q;

    // A new overrun outranks a simultaneous write-one-to-clear.
    rx_ovr_d = rx_ovr_q;
    if (wr_ok && sel == 2'd1 && PWDATA[4]) rx_ovr_d = 1'b0;
    if (capture && rx_valid_q && !rx_clr)  rx_ovr_d = 1'b1;

    irq_d = ctrl_d[1] & (rx_valid_d | rx_ovr_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctrl_q     <= '0;
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      data_in_q  <= '0;
      rx_reg_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
      data_in_q  <= data_in_d;
      rx_reg_q   <= rx_reg_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      irq_q      <= irq_d;
    end
  end

  assign PRDATA  = prdata;
  assign PSLVERR = pslverr;
  assign PREADY  = 1'b1;
  assign send    = (state_q == ST_LAUNCH);
  assign data_in = data_in_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_apb_spi_bridge.sv
// Directed bench for apb_spi_bridge with a small SPI core responder that
// answers each transfer with the nibble-reversed transmit word.
module tb_apb_spi_bridge;

  logic        clk, nrst;
  logic [3:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        send, done, irq;
  logic [15:0] data_in, data_out;

  int          n_cmp, n_bad;
  int          send_cycles;
  logic [15:0] sent_log [$];
  int          core_lat;

  apb_spi_bridge #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .nrst(nrst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .send(send), .data_in(data_in), .data_out(data_out),
    .done(done), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send) begin
      send_cycles++;
      sent_log.push_back(data_in);
    end
  end

  // SPI core responder: done arrives core_lat edges after the send cycle.
  initial begin
    logic [15:0] d;
    done = 1'b0;
    data_out = '0;
    forever begin
      @(negedge clk);
      if (send) begin
        d = data_in;
        repeat (core_lat) @(posedge clk);
        #1;
        done = 1'b1;
        data_out = {d[3:0], d[7:4], d[11:8], d[15:12]};
        @(posedge clk);
        #1;
        done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = wr; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    rd = PRDATA;
    err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, output logic err);
    logic [31:0] rd;
    apb(1'b1, a, d, rd, err);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic err;
    apb(1'b0, a, 32'h0, rd, err);
    check(tag, rd, exp);
  endtask

  task automatic wait_sends(input string tag, input int target);
    int budget;
    budget = 200;
    while (send_cycles < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (send_cycles < target) check(tag, send_cycles, target);
    repeat (core_lat + 4) @(posedge clk);
  endtask

  initial begin
    logic err;
    logic [31:0] rd;
    int base, budget;
    n_cmp = 0; n_bad = 0; send_cycles = 0; core_lat = 3;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_send", send, 0);
    check("rst_prdata_idle", PRDATA, 0);
    check("rst_pslverr_idle", PSLVERR, 0);
    check("rst_irq", irq, 0);
    check("rst_data_in", data_in, 0);
    rd_chk("rst_status", 4'h4, 32'h0000_0004);
    rd_chk("rst_ctrl", 4'h0, 32'h0);

    // Single transfer with interrupt
    wr(4'h0, 32'h3, err);
    wr(4'h8, 32'hA5C3, err);
    check("tx1_err", err, 0);
    wait_sends("tx1_timeout", 1);
    check("tx1_sends", send_cycles, 1);
    check("tx1_data", sent_log[0], 16'hA5C3);
    check("tx1_irq_hi", irq, 1);
    rd_chk("tx1_status", 4'h4, 32'h0000_000C);
    rd_chk("tx1_rxdata", 4'hC, 32'h0000_3C5A);
    @(negedge clk);
    check("tx1_irq_lo", irq, 0);

    // Address errors
    apb(1'b0, 4'h5, 32'h0, rd, err);
    check("misalign_rd_err", err, 1);
    check("misalign_rd_data", rd, 0);
    wr(4'h1, 32'h0, err);
    check("misalign_wr_err", err, 1);
    rd_chk("misalign_ctrl_kept", 4'h0, 32'h3);

    // FIFO fill with EN=0
    wr(4'h0, 32'h2, err);
    for (int i = 1; i <= 5; i++) begin
      wr(4'h8, i, err);
      check($sformatf("fill_err_%0d", i), err, (i == 5) ? 1 : 0);
    end
    rd_chk("fill_status", 4'h4, 32'h0000_0402);
    check("fill_no_send", send_cycles, 1);
    base = send_cycles;
    wr(4'h0, 32'h3, err);
    wait_sends("drain_timeout", base + 4);
    check("drain_count", send_cycles, base + 4);
    check("drain_w1", sent_log[base+0], 16'h0001);
    check("drain_w2", sent_log[base+1], 16'h0002);
    check("drain_w3", sent_log[base+2], 16'h0003);
    check("drain_w4", sent_log[base+3], 16'h0004);
    rd_chk("drain_status", 4'h4, 32'h0000_001C);
    rd_chk("drain_rxdata", 4'hC, 32'h0000_4000);
    wr(4'h4, 32'h10, err);
    rd_chk("drain_w1c", 4'h4, 32'h0000_0004);

    // Overrun from two unread transfers
    base = send_cycles;
    wr(4'h8, 32'h1234, err);
    wr(4'h8, 32'h00F0, err);
    wait_sends("ovr_timeout", base + 2);
    check("ovr_irq", irq, 1);
    rd_chk("ovr_status", 4'h4, 32'h0000_001C);
    rd_chk("ovr_rxdata", 4'hC, 32'h0000_0F00);
    rd_chk("ovr_status_rd", 4'h4, 32'h0000_0014);
    wr(4'h4, 32'h10, err);
    rd_chk("ovr_w1c", 4'h4, 32'h0000_0004);
    @(negedge clk);
    check("ovr_irq_lo", irq, 0);

    // RXDATA read coincident with done
    base = send_cycles;
    wr(4'h8, 32'h0011, err);
    wait_sends("coin_pre_timeout", base + 1);
    rd_chk("coin_pre_status", 4'h4, 32'h0000_000C);
    core_lat = 2;
    base = send_cycles;
    wr(4'h8, 32'h2233, err);
    budget = 20;
    while (!send && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("coin_send_seen", send, 1);
    rd_chk("coin_rxdata_old", 4'hC, 32'h0000_1100);
    rd_chk("coin_status", 4'h4, 32'h0000_000C);
    rd_chk("coin_rxdata_new", 4'hC, 32'h0000_3322);
    core_lat = 3;
    repeat (4) @(posedge clk);

    // Reset during WAIT with two words queued
    core_lat = 8;
    wr(4'h8, 32'h0101, err);
    wr(4'h8, 32'h0202, err);
    wr(4'h8, 32'h0303, err);
    rd_chk("wait_status", 4'h4, 32'h0000_0201);
    nrst = 1'b0;
    #1;
    check("arst_send", send, 0);
    check("arst_status_bits", {dut.rx_valid_q, irq}, 0);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    core_lat = 3;
    base = send_cycles;
    repeat (20) @(posedge clk);
    check("arst_no_send", send_cycles, base);
    rd_chk("arst_status", 4'h4, 32'h0000_0004);
    rd_chk("arst_ctrl", 4'h0, 32'h0);
    wr(4'h0, 32'h1, err);
    wr(4'h8, 32'h0BAD, err);
    wait_sends("arst_new_timeout", base + 1);
    repeat (10) @(posedge clk);
    check("arst_new_count", send_cycles, base + 1);
    check("arst_new_data", sent_log[base], 16'h0BAD);
    rd_chk("arst_new_rx", 4'hC, 32'h0000_DAB0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
